// File: rtl/router_pkg.sv
// Shared definitions for the router datapath: checksum modes, address width
// helper and the checksum-combine function.
package router_pkg;

    localparam int unsigned CHK_XOR   = 0;
    localparam int unsigned CHK_SUM   = 1;
    localparam int unsigned CHK_MAX_W = 64;

    function automatic int unsigned addr_width(input int unsigned channels);
        return (channels > 2) ? $clog2(channels) : 1;
    endfunction

    // Callers zero-extend into CHK_MAX_W and truncate the result, which yields
    // sum modulo 2^DATA_W for the additive mode.
    function automatic logic [CHK_MAX_W-1:0] chk_op(input int unsigned mode,
                                                    input logic [CHK_MAX_W-1:0] a,
                                                    input logic [CHK_MAX_W-1:0] b);
        return (mode == CHK_SUM) ? (a + b) : (a ^ b);
    endfunction

endpackage

// File: rtl/router_skid_fifo.sv
// Circular skid buffer with push/pop/count; simultaneous push and pop is
// accepted even when full.
module router_skid_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        rdata   = mem[rd_ptr];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/router_reg_param.sv
// Router input register stage: header latch, dout mux with skid buffering,
// running checksum and trailer comparison.
module router_reg_param
    import router_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned CHANNELS   = 3,
    parameter int unsigned SKID_DEPTH = 2,
    parameter int unsigned CHK_MODE   = CHK_XOR
) (
    input  logic                              clock,
    input  logic                              resetn,
    input  logic                              pkt_valid,
    input  logic [DATA_W-1:0]                 data_in,
    input  logic                              fifo_full,
    input  logic                              detect_add,
    input  logic                              lfd_state,
    input  logic                              ld_state,
    input  logic                              laf_state,
    input  logic                              full_state,
    input  logic                              rst_int_reg,
    output logic [DATA_W-1:0]                 dout,
    output logic                              dout_valid,
    output logic                              low_packet_valid,
    output logic                              parity_done,
    output logic                              err,
    output logic                              skid_ovf,
    output logic [$clog2(SKID_DEPTH+1)-1:0]   skid_count
);

    localparam int unsigned AW = addr_width(CHANNELS);
    localparam int unsigned EW = DATA_W + 1;

    logic [DATA_W-1:0] header;
    logic [DATA_W-1:0] chk;
    logic [DATA_W-1:0] packet_parity;
    logic              dout_tag;

    logic              sel_da, sel_lfd, sel_ld, sel_laf;
    logic              addr_ok, ld_direct, do_pop, do_push, drop;
    logic              write_dout, chk_update, tag_next;
    logic [DATA_W-1:0] dout_next, chk_in, chk_next;
    logic [EW-1:0]     skid_head;
    logic              skid_full, skid_empty;

    always_comb begin
        sel_da  = detect_add;
        sel_lfd = !detect_add && lfd_state;
        sel_ld  = !detect_add && !lfd_state && ld_state;
        sel_laf = !detect_add && !lfd_state && !ld_state && laf_state && !full_state;

        addr_ok = pkt_valid && (32'(data_in[AW-1:0]) < CHANNELS);

        // With bytes waiting in the skid, the head goes out and the new byte
        // queues behind it so ordering is preserved.
        ld_direct  = sel_ld && !fifo_full && skid_empty;
        do_pop     = (sel_ld || sel_laf) && !fifo_full && !skid_empty;
        drop       = sel_ld && fifo_full && skid_full;
        do_push    = sel_ld && !ld_direct && !drop;
        write_dout = sel_lfd || ld_direct || do_pop;

        dout_next = header;
        tag_next  = 1'b0;
        if (do_pop) begin
            {tag_next, dout_next} = skid_head;
        end else if (ld_direct) begin
            dout_next = data_in;
            tag_next  = !pkt_valid;
        end

        chk_update = sel_lfd || (sel_ld && pkt_valid && !drop);
        chk_in     = sel_lfd ? header : data_in;
        chk_next   = DATA_W'(chk_op(CHK_MODE, CHK_MAX_W'(chk), CHK_MAX_W'(chk_in)));
    end

    router_skid_fifo #(
        .WIDTH (EW),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clock  (clock),
        .resetn (resetn),
        .clear  (sel_da),
        .push   (do_push),
        .pop    (do_pop),
        .wdata  ({!pkt_valid, data_in}),
        .rdata  (skid_head),
        .count  (skid_count),
        .full   (skid_full),
        .empty  (skid_empty)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            header           <= '0;
            chk              <= '0;
            packet_parity    <= '0;
            dout             <= '0;
            dout_valid       <= 1'b0;
            dout_tag         <= 1'b0;
            low_packet_valid <= 1'b0;
            parity_done      <= 1'b0;
            err              <= 1'b0;
            skid_ovf         <= 1'b0;
        end else begin
            dout_valid <= write_dout;
            dout_tag   <= write_dout && tag_next;
            if (write_dout) begin
                dout <= dout_next;
            end

            if (sel_da) begin
                chk         <= '0;
                parity_done <= 1'b0;
                err         <= 1'b0;
                skid_ovf    <= 1'b0;
                if (addr_ok) begin
                    header <= data_in;
                end
            end else begin
                if (chk_update) begin
                    chk <= chk_next;
                end
                if (dout_tag) begin
                    parity_done <= 1'b1;
                end
                if (parity_done && (chk != packet_parity)) begin
                    err <= 1'b1;
                end
                if (drop) begin
                    skid_ovf <= 1'b1;
                end
            end

            if (sel_ld && !pkt_valid) begin
                packet_parity <= data_in;
            end

            if (rst_int_reg) begin
                low_packet_valid <= 1'b0;
            end else if (sel_ld && !pkt_valid) begin
                low_packet_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_router_reg_param.sv
// Bench for router_reg_param: XOR and additive-checksum instances share stimulus;
// a queue-based monitor checks every dout write, directed checks cover the flags.
module tb_router_reg_param;

    localparam logic [4:0] S_IDLE = 5'b00000;
    localparam logic [4:0] S_DA   = 5'b10000;
    localparam logic [4:0] S_LFD  = 5'b01000;
    localparam logic [4:0] S_LD   = 5'b00100;
    localparam logic [4:0] S_LAF  = 5'b00010;

    logic       clock;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;

    logic [7:0] do_x, do_s;
    logic       dv_x, dv_s, lpv_x, lpv_s, pd_x, pd_s, err_x, err_s, ovf_x, ovf_s;
    logic [1:0] cnt_x, cnt_s;

    int         checks = 0;
    int         passes = 0;
    logic [7:0] exp_q[$];

    router_reg_param #(
        .DATA_W     (8),
        .CHANNELS   (3),
        .SKID_DEPTH (2),
        .CHK_MODE   (0)
    ) u_xor (
        .clock            (clock),
        .resetn           (resetn),
        .pkt_valid        (pkt_valid),
        .data_in          (data_in),
        .fifo_full        (fifo_full),
        .detect_add       (detect_add),
        .lfd_state        (lfd_state),
        .ld_state         (ld_state),
        .laf_state        (laf_state),
        .full_state       (full_state),
        .rst_int_reg      (rst_int_reg),
        .dout             (do_x),
        .dout_valid       (dv_x),
        .low_packet_valid (lpv_x),
        .parity_done      (pd_x),
        .err              (err_x),
        .skid_ovf         (ovf_x),
        .skid_count       (cnt_x)
    );

    router_reg_param #(
        .DATA_W     (8),
        .CHANNELS   (3),
        .SKID_DEPTH (2),
        .CHK_MODE   (1)
    ) u_sum (
        .clock            (clock),
        .resetn           (resetn),
        .pkt_valid        (pkt_valid),
        .data_in          (data_in),
        .fifo_full        (fifo_full),
        .detect_add       (detect_add),
        .lfd_state        (lfd_state),
        .ld_state         (ld_state),
        .laf_state        (laf_state),
        .full_state       (full_state),
        .rst_int_reg      (rst_int_reg),
        .dout             (do_s),
        .dout_valid       (dv_s),
        .low_packet_valid (lpv_s),
        .parity_done      (pd_s),
        .err              (err_s),
        .skid_ovf         (ovf_s),
        .skid_count       (cnt_s)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc(input logic [4:0] st, input logic pv, input logic [7:0] d,
                       input logic ff, input logic rir);
        {detect_add, lfd_state, ld_state, laf_state, full_state} = st;
        pkt_valid   = pv;
        data_in     = d;
        fifo_full   = ff;
        rst_int_reg = rir;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        cyc(S_IDLE, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Scoreboard monitor: each dout write must match the next queued byte.
    always @(negedge clock) begin
        if (resetn && (dv_x || dv_s)) begin
            check("dv_agree", {31'b0, dv_s}, {31'b0, dv_x});
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL dout_unexpected: got %0h expected no write at %0t", do_x, $time);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("dout_xor", {24'b0, do_x}, {24'b0, e});
                check("dout_sum", {24'b0, do_s}, {24'b0, e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    task automatic send_t1_packet();
        cyc(S_DA, 1'b1, 8'h05, 1'b0, 1'b0);
        exp_q.push_back(8'h05); cyc(S_LFD, 1'b1, 8'h05, 1'b0, 1'b0);
        exp_q.push_back(8'h11); cyc(S_LD,  1'b1, 8'h11, 1'b0, 1'b0);
        exp_q.push_back(8'h22); cyc(S_LD,  1'b1, 8'h22, 1'b0, 1'b0);
        exp_q.push_back(8'h36); cyc(S_LD,  1'b0, 8'h36, 1'b0, 1'b0);
    endtask

    initial begin
        resetn = 1'b0;
        {detect_add, lfd_state, ld_state, laf_state, full_state} = S_IDLE;
        pkt_valid = 1'b0; data_in = 8'h00; fifo_full = 1'b0; rst_int_reg = 1'b0;
        #12;
        check("rst_dout", {24'b0, do_x}, 0);
        check("rst_dv", {31'b0, dv_x}, 0);
        check("rst_lpv", {31'b0, lpv_x}, 0);
        check("rst_pd", {31'b0, pd_x}, 0);
        check("rst_err", {31'b0, err_x}, 0);
        check("rst_ovf", {31'b0, ovf_x}, 0);
        check("rst_cnt", {30'b0, cnt_x}, 0);
        check("rst_dout_sum", {24'b0, do_s}, 0);
        resetn = 1'b1;
        @(posedge clock); #1;

        // XOR packet 05 11 22 / 36: matches XOR, sum is 38
        send_t1_packet();
        check("t1_lpv", {31'b0, lpv_x}, 1);
        check("t1_pd_early", {31'b0, pd_x}, 0);
        idle();
        check("t1_pd", {31'b0, pd_x}, 1);
        check("t1_err_early_sum", {31'b0, err_s}, 0);
        idle();
        check("t1_err_xor", {31'b0, err_x}, 0);
        check("t1_err_sum", {31'b0, err_s}, 1);
        cyc(S_IDLE, 1'b0, 8'h00, 1'b0, 1'b1);
        check("t1_lpv_clr", {31'b0, lpv_x}, 0);

        // Sum packet FE 03 / 01: sum wraps to 01, XOR gives FD
        cyc(S_DA, 1'b1, 8'hFE, 1'b0, 1'b0);
        check("t2_da_err_clr", {31'b0, err_s}, 0);
        check("t2_da_pd_clr", {31'b0, pd_s}, 0);
        exp_q.push_back(8'hFE); cyc(S_LFD, 1'b1, 8'hFE, 1'b0, 1'b0);
        exp_q.push_back(8'h03); cyc(S_LD,  1'b1, 8'h03, 1'b0, 1'b0);
        exp_q.push_back(8'h01); cyc(S_LD,  1'b0, 8'h01, 1'b0, 1'b0);
        idle(); idle();
        check("t2_err_sum_ok", {31'b0, err_s}, 0);
        check("t2_err_xor", {31'b0, err_x}, 1);

        // Same packet, wrong trailer 02: err two cycles after trailer on dout
        cyc(S_DA, 1'b1, 8'hFE, 1'b0, 1'b0);
        exp_q.push_back(8'hFE); cyc(S_LFD, 1'b1, 8'hFE, 1'b0, 1'b0);
        exp_q.push_back(8'h03); cyc(S_LD,  1'b1, 8'h03, 1'b0, 1'b0);
        exp_q.push_back(8'h02); cyc(S_LD,  1'b0, 8'h02, 1'b0, 1'b0);
        idle();
        check("t2b_err_early", {31'b0, err_s}, 0);
        idle();
        check("t2b_err_sum", {31'b0, err_s}, 1);

        // Skid buffering: A1, A2 held while full, drained in laf
        cyc(S_DA, 1'b1, 8'h01, 1'b0, 1'b0);
        exp_q.push_back(8'h01); cyc(S_LFD, 1'b1, 8'h01, 1'b0, 1'b0);
        cyc(S_LD, 1'b1, 8'hA1, 1'b1, 1'b0);
        check("t3_cnt1", {30'b0, cnt_x}, 1);
        cyc(S_LD, 1'b1, 8'hA2, 1'b1, 1'b0);
        check("t3_cnt2", {30'b0, cnt_x}, 2);
        check("t3_ovf", {31'b0, ovf_x}, 0);
        exp_q.push_back(8'hA1); cyc(S_LAF, 1'b0, 8'h00, 1'b0, 1'b0);
        check("t3_cnt_pop1", {30'b0, cnt_x}, 1);
        exp_q.push_back(8'hA2); cyc(S_LAF, 1'b0, 8'h00, 1'b0, 1'b0);
        check("t3_cnt_pop2", {30'b0, cnt_x}, 0);
        exp_q.push_back(8'h02); cyc(S_LD, 1'b0, 8'h02, 1'b0, 1'b0);
        idle(); idle();
        check("t3_pd", {31'b0, pd_x}, 1);
        check("t3_err_xor", {31'b0, err_x}, 0);
        check("t3_err_sum", {31'b0, err_s}, 1);
        check("t3_ovf_end", {31'b0, ovf_x}, 0);

        // Overflow: B3 dropped; trailer B2 covers B3 so the checksum mismatches.
        // Trailer arrives with skid full and is pushed while B1 pops.
        cyc(S_DA, 1'b1, 8'h02, 1'b0, 1'b0);
        exp_q.push_back(8'h02); cyc(S_LFD, 1'b1, 8'h02, 1'b0, 1'b0);
        cyc(S_LD, 1'b1, 8'hB1, 1'b1, 1'b0);
        cyc(S_LD, 1'b1, 8'hB2, 1'b1, 1'b0);
        check("t4_ovf_pre", {31'b0, ovf_x}, 0);
        cyc(S_LD, 1'b1, 8'hB3, 1'b1, 1'b0);
        check("t4_ovf", {31'b0, ovf_x}, 1);
        check("t4_cnt_full", {30'b0, cnt_x}, 2);
        exp_q.push_back(8'hB1); cyc(S_LD, 1'b0, 8'hB2, 1'b0, 1'b0);
        check("t4_cnt_pushpop", {30'b0, cnt_x}, 2);
        exp_q.push_back(8'hB2); cyc(S_LAF, 1'b0, 8'h00, 1'b0, 1'b0);
        exp_q.push_back(8'hB2); cyc(S_LAF, 1'b0, 8'h00, 1'b0, 1'b0);
        check("t4_cnt_empty", {30'b0, cnt_x}, 0);
        check("t4_pd_early", {31'b0, pd_x}, 0);
        idle();
        check("t4_pd", {31'b0, pd_x}, 1);
        idle();
        check("t4_err_xor", {31'b0, err_x}, 1);
        check("t4_err_sum", {31'b0, err_s}, 1);

        // Invalid address 07: header stays 02, flags and checksum still cleared
        cyc(S_DA, 1'b1, 8'h07, 1'b0, 1'b0);
        check("t5_ovf_clr", {31'b0, ovf_x}, 0);
        check("t5_err_clr", {31'b0, err_x}, 0);
        check("t5_pd_clr", {31'b0, pd_x}, 0);
        check("t5_cnt_clr", {30'b0, cnt_x}, 0);
        exp_q.push_back(8'h02); cyc(S_LFD, 1'b1, 8'h07, 1'b0, 1'b0);
        exp_q.push_back(8'h02); cyc(S_LD, 1'b0, 8'h02, 1'b0, 1'b1);
        check("t5_lpv_rst_prio", {31'b0, lpv_x}, 0);
        idle(); idle();
        check("t5_pd", {31'b0, pd_x}, 1);
        check("t5_err_xor", {31'b0, err_x}, 0);
        check("t5_err_sum", {31'b0, err_s}, 0);

        // Async reset mid-payload with one byte in the skid
        cyc(S_DA, 1'b1, 8'h01, 1'b0, 1'b0);
        exp_q.push_back(8'h01); cyc(S_LFD, 1'b1, 8'h01, 1'b0, 1'b0);
        cyc(S_LD, 1'b1, 8'h55, 1'b1, 1'b0);
        check("t6_cnt_pre", {30'b0, cnt_x}, 1);
        #2;
        resetn = 1'b0;
        {detect_add, lfd_state, ld_state, laf_state, full_state} = S_IDLE;
        pkt_valid = 1'b0; data_in = 8'h00; fifo_full = 1'b0;
        #1;
        check("t6_dout", {24'b0, do_x}, 0);
        check("t6_cnt", {30'b0, cnt_x}, 0);
        check("t6_lpv", {31'b0, lpv_x}, 0);
        check("t6_dout_sum", {24'b0, do_s}, 0);
        @(posedge clock); #1;
        resetn = 1'b1;
        send_t1_packet();
        idle(); idle();
        check("t6_pd", {31'b0, pd_x}, 1);
        check("t6_err_xor", {31'b0, err_x}, 0);
        check("t6_err_sum", {31'b0, err_s}, 1);

        idle();
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
